// File: rtl/trap_ctrl_if.sv
// Bus between the pipeline/CSR file (master side) and the trap sequencer (slave side).
// Carries trap/MRET requests, the CSR file port and the fetch redirect.
interface trap_ctrl_if;
    logic        trap_req;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_tval;
    logic        mret_req;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wd;
    logic [31:0] csr_rd;
    logic        busy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output trap_req, trap_cause, trap_pc, trap_tval, mret_req, csr_rd,
        input  csr_we, csr_addr, csr_wd, busy, redirect_valid, redirect_pc
    );

    modport slave (
        input  trap_req, trap_cause, trap_pc, trap_tval, mret_req, csr_rd,
        output csr_we, csr_addr, csr_wd, busy, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap entry / MRET sequencer: walks the CSR file one access per cycle,
// saving trap state and updating mstatus, then issues a single-cycle fetch redirect.
module trap_ctrl #(
    parameter logic VECTORED_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    trap_ctrl_if.slave  bus
);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] W_MEPC   = 4'd1;
    localparam logic [3:0] W_MCAUSE = 4'd2;
    localparam logic [3:0] W_MTVAL  = 4'd3;
    localparam logic [3:0] R_MSTAT  = 4'd4;
    localparam logic [3:0] W_MSTAT  = 4'd5;
    localparam logic [3:0] R_MTVEC  = 4'd6;
    localparam logic [3:0] R_MEPC   = 4'd7;
    localparam logic [3:0] REDIRECT = 4'd8;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;

    logic [3:0]  state_q,     state_d;
    logic        is_mret_q,   is_mret_d;
    logic [31:0] cause_q,     cause_d;
    logic [31:0] pc_q,        pc_d;
    logic [31:0] tval_q,      tval_d;
    logic [31:0] mstat_q,     mstat_d;
    logic [31:0] target_q,    target_d;
    logic [31:0] redir_pc_q,  redir_pc_d;

    logic [31:0] mstat_wr;
    logic [31:0] mtvec_base;
    logic [31:0] trap_target;

    // Vectored mode only applies to interrupts; reserved modes 2'b10/2'b11 fall back to direct.
    always_comb begin
        mtvec_base  = {bus.csr_rd[31:2], 2'b00};
        trap_target = mtvec_base;
        if (VECTORED_EN && (bus.csr_rd[1:0] == 2'b01) && cause_q[31]) begin
            trap_target = mtvec_base + {cause_q[29:0], 2'b00};
        end
    end

    always_comb begin
        mstat_wr = mstat_q;
        if (is_mret_q) begin
            mstat_wr[3] = mstat_q[7];
            mstat_wr[7] = 1'b1;
        end else begin
            mstat_wr[7] = mstat_q[3];
            mstat_wr[3] = 1'b0;
        end
        mstat_wr[12:11] = 2'b11;
    end

    always_comb begin
        state_d    = state_q;
        is_mret_d  = is_mret_q;
        cause_d    = cause_q;
        pc_d       = pc_q;
        tval_d     = tval_q;
        mstat_d    = mstat_q;
        target_d   = target_q;
        redir_pc_d = redir_pc_q;
        case (state_q)
            IDLE: begin
                if (bus.trap_req) begin
                    cause_d   = bus.trap_cause;
                    pc_d      = bus.trap_pc;
                    tval_d    = bus.trap_tval;
                    is_mret_d = 1'b0;
                    state_d   = W_MEPC;
                end else if (bus.mret_req) begin
                    is_mret_d = 1'b1;
                    state_d   = R_MSTAT;
                end
            end
            W_MEPC:   state_d = W_MCAUSE;
            W_MCAUSE: state_d = W_MTVAL;
            W_MTVAL:  state_d = R_MSTAT;
            R_MSTAT: begin
                mstat_d = bus.csr_rd;
                state_d = W_MSTAT;
            end
            W_MSTAT:  state_d = is_mret_q ? R_MEPC : R_MTVEC;
            R_MTVEC: begin
                target_d = trap_target;
                state_d  = REDIRECT;
            end
            R_MEPC: begin
                target_d = {bus.csr_rd[31:2], 2'b00};
                state_d  = REDIRECT;
            end
            REDIRECT: begin
                redir_pc_d = target_q;
                state_d    = IDLE;
            end
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.csr_we   = 1'b0;
        bus.csr_addr = 12'h000;
        bus.csr_wd   = 32'h0;
        case (state_q)
            W_MEPC: begin
                bus.csr_we   = 1'b1;
                bus.csr_addr = ADDR_MEPC;
                bus.csr_wd   = {pc_q[31:2], 2'b00};
            end
            W_MCAUSE: begin
                bus.csr_we   = 1'b1;
                bus.csr_addr = ADDR_MCAUSE;
                bus.csr_wd   = cause_q;
            end
            W_MTVAL: begin
                bus.csr_we   = 1'b1;
                bus.csr_addr = ADDR_MTVAL;
                bus.csr_wd   = tval_q;
            end
            R_MSTAT:  bus.csr_addr = ADDR_MSTATUS;
            W_MSTAT: begin
                bus.csr_we   = 1'b1;
                bus.csr_addr = ADDR_MSTATUS;
                bus.csr_wd   = mstat_wr;
            end
            R_MTVEC:  bus.csr_addr = ADDR_MTVEC;
            R_MEPC:   bus.csr_addr = ADDR_MEPC;
            default:  ;
        endcase
    end

    // redirect_pc shows the fresh target during REDIRECT and keeps it until the next one.
    always_comb begin
        bus.busy           = (state_q != IDLE);
        bus.redirect_valid = (state_q == REDIRECT);
        bus.redirect_pc    = (state_q == REDIRECT) ? target_q : redir_pc_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            is_mret_q  <= 1'b0;
            cause_q    <= 32'h0;
            pc_q       <= 32'h0;
            tval_q     <= 32'h0;
            mstat_q    <= 32'h0;
            target_q   <= 32'h0;
            redir_pc_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            is_mret_q  <= is_mret_d;
            cause_q    <= cause_d;
            pc_q       <= pc_d;
            tval_q     <= tval_d;
            mstat_q    <= mstat_d;
            target_q   <= target_d;
            redir_pc_q <= redir_pc_d;
        end
    end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 The block SHALL have parameter VECTORED_EN, default 1, which enables mtvec vectored mode for interrupts when set to 1.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port trap_req, input, 1 bit: exception or interrupt request, sampled only in IDLE.
REQ-005 The block SHALL have ports trap_cause, trap_pc and trap_tval, input, 32 bits each: mcause value, faulting PC and mtval value; trap_cause[31]=1 marks an interrupt.
REQ-006 The block SHALL have port mret_req, input, 1 bit: MRET request, sampled only in IDLE.
REQ-007 The block SHALL have port csr_we, output, 1 bit: CSR file write enable.
REQ-008 The block SHALL have port csr_addr, output, 12 bits: CSR file address, shared by read and write.
REQ-009 The block SHALL have port csr_wd, output, 32 bits: CSR file write data.
REQ-010 The block SHALL have port csr_rd, input, 32 bits: combinational CSR file read data for csr_addr.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-012 The block SHALL have port redirect_valid, output, 1 bit: one-cycle pulse indicating that redirect_pc is valid.
REQ-013 The block SHALL have port redirect_pc, output, 32 bits: next fetch PC.

Function
REQ-014 The block SHALL use FSM states IDLE, W_MEPC, W_MCAUSE, W_MTVAL, R_MSTAT, W_MSTAT, R_MTVEC, R_MEPC and REDIRECT.
REQ-015 In IDLE with trap_req=1, the block SHALL latch trap_cause, trap_pc and trap_tval, set the mode flag to TRAP, and go to W_MEPC.
REQ-016 In IDLE with mret_req=1 and trap_req=0, the block SHALL set the mode flag to MRET and go to R_MSTAT.
REQ-017 When trap_req and mret_req are both high in IDLE, trap SHALL win and the mret request SHALL be dropped.
REQ-018 Requests arriving while busy=1 SHALL be ignored; the requester holds them until it observes busy=0.
REQ-019 The trap path SHALL be W_MEPC -> W_MCAUSE -> W_MTVAL -> R_MSTAT -> W_MSTAT -> R_MTVEC -> REDIRECT -> IDLE, one cycle per state, with redirect_valid asserted 7 cycles after the accept edge.
REQ-020 The MRET path SHALL be R_MSTAT -> W_MSTAT -> R_MEPC -> REDIRECT -> IDLE, with redirect_valid asserted 4 cycles after the accept edge.
REQ-021 In W_MEPC, the block SHALL drive csr_we=1, csr_addr=0x341 and csr_wd={pc[31:2],2'b00}.
REQ-022 In W_MCAUSE, the block SHALL drive csr_we=1, csr_addr=0x342 and csr_wd=the latched cause.
REQ-023 In W_MTVAL, the block SHALL drive csr_we=1, csr_addr=0x343 and csr_wd=the latched tval.
REQ-024 In R_MSTAT, the block SHALL drive csr_we=0 and csr_addr=0x300, and latch csr_rd into mstat_q at the end of the cycle.
REQ-025 In W_MSTAT for a trap, the block SHALL drive csr_addr=0x300, csr_we=1 and csr_wd=mstat_q with bit7 (MPIE) set to mstat_q[3], bit3 (MIE) set to 0, and bits 12:11 (MPP) set to 2'b11, all other bits unchanged.
REQ-026 In W_MSTAT for MRET, the block SHALL drive csr_wd=mstat_q with bit3 set to mstat_q[7], bit7 set to 1, and bits 12:11 set to 2'b11.
REQ-027 In R_MTVEC, the block SHALL drive csr_addr=0x305 and latch the redirect target computed from csr_rd.
REQ-028 In R_MEPC, the block SHALL drive csr_addr=0x341 and latch the redirect target computed from csr_rd.
REQ-029 For the trap path, the redirect target SHALL be base={mtvec[31:2],2'b00}; when VECTORED_EN=1, mtvec[1:0]=2'b01 and cause[31]=1, the target SHALL be base+{cause[29:0],2'b00}, computed modulo 2^32.
REQ-030 An mtvec[1:0] value of 2'b10 or 2'b11 SHALL be treated as direct mode.
REQ-031 For the MRET path, the redirect target SHALL be {mepc[31:2],2'b00}.
REQ-032 In REDIRECT, the block SHALL drive redirect_valid=1 and redirect_pc=the latched target; redirect_pc SHALL hold its value after REDIRECT until the next REDIRECT.
REQ-033 In all states other than the W_* states, the block SHALL drive csr_we=0; in IDLE it SHALL drive csr_addr=0x000 and csr_wd=0.
REQ-034 The block SHALL produce no back-to-back accept in the cycle after REDIRECT unless a request is present in IDLE.

Reset
REQ-035 When rst=0 at a rising edge, the block SHALL force state to IDLE and clear csr_we, csr_addr, csr_wd, busy, redirect_valid, redirect_pc, mstat_q and all latched fields to 0.
REQ-036 Reset asserted mid-sequence SHALL abort the sequence with no further CSR writes and no redirect; CSR writes already issued SHALL stand.
REQ-037 The block SHALL ignore requests while rst=0.

Verification
REQ-038 Scenario, direct trap: mtvec=0x00000100, mstatus=0x00000008, trap cause=2, pc=0x80, tval=0xDEAD -> writes mepc=0x80, mcause=2, mtval=0xDEAD and mstatus=0x00001880, then redirect_pc=0x100 seven cycles after accept.
REQ-039 Scenario, vectored interrupt: mtvec=0x00000101, cause=0x80000007 -> redirect_pc=0x11C; with VECTORED_EN=0 -> redirect_pc=0x100.
REQ-040 Scenario, MRET: mstatus=0x00001880, mepc=0x84 -> mstatus written as 0x00001888 and redirect_pc=0x84 four cycles after accept.
REQ-041 Scenario, simultaneous trap_req and mret_req -> trap path only; a trap_req pulse during busy -> no second sequence.
REQ-042 Scenario, rst=0 asserted in W_MTVAL -> next cycle IDLE, csr_we=0, and no redirect_valid pulse ever appears.
REQ-043 Scenario, back-to-back: trap held high across REDIRECT -> re-accepted in IDLE the cycle after REDIRECT, with correct second-sequence writes.
